// File: rtl/mod_counter_pkg.sv
// Shared types and default sizing for the modulo-N counter family.
// Optional build feature: MOD_COUNTER_WRAP_CNT_EN adds the wrap-event counter.
package mod_counter_pkg;

  typedef enum logic {
    CNT_DOWN = 1'b0,
    CNT_UP   = 1'b1
  } cnt_mode_e;

  localparam int DEF_WIDTH   = 4;
  localparam int DEF_MODULUS = 12;
  localparam int DEF_WRAP_W  = 8;

  function automatic cnt_mode_e to_mode(input logic m);
    return m ? CNT_UP : CNT_DOWN;
  endfunction

endpackage

// File: rtl/mod_next_value.sv
// Combinational next-count, wrap detection and load clamping for mod_n_counter.
// Arithmetic is done one bit wider than the count so MODULUS = 2^WIDTH compares cleanly.
module mod_next_value
  import mod_counter_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int MODULUS = DEF_MODULUS
) (
  input  logic [WIDTH-1:0] count,
  input  cnt_mode_e        mode,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] count_next,
  output logic [WIDTH-1:0] load_value,
  output logic             wrap
);

  localparam logic [WIDTH:0] MOD_EXT = (WIDTH + 1)'(MODULUS);
  localparam logic [WIDTH:0] TOP_EXT = (WIDTH + 1)'(MODULUS - 1);

  logic [WIDTH:0] count_ext;
  logic [WIDTH:0] data_in_ext;
  logic [WIDTH:0] next_ext;
  logic [WIDTH:0] load_ext;

  assign count_ext   = {1'b0, count};
  assign data_in_ext = {1'b0, data_in};

  always_comb begin
    wrap     = 1'b0;
    next_ext = count_ext;
    if (mode == CNT_UP) begin
      if (count_ext == TOP_EXT) begin
        wrap     = 1'b1;
        next_ext = '0;
      end else begin
        next_ext = count_ext + 1'b1;
      end
    end else begin
      if (count_ext == '0) begin
        wrap     = 1'b1;
        next_ext = TOP_EXT;
      end else begin
        next_ext = count_ext - 1'b1;
      end
    end
  end

  // Out-of-range load values saturate to the top of the count range.
  assign load_ext   = (data_in_ext < MOD_EXT) ? data_in_ext : TOP_EXT;
  assign count_next = WIDTH'(next_ext);
  assign load_value = WIDTH'(load_ext);

endmodule

// File: rtl/mod_n_counter.sv
// Loadable up/down modulo-N counter with registered terminal-count pulse.
// Define MOD_COUNTER_WRAP_CNT_EN to add the wrap_cnt port and its register.
module mod_n_counter
  import mod_counter_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int MODULUS = DEF_MODULUS,
  parameter int WRAP_W  = DEF_WRAP_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  input  logic             mode,
  output logic [WIDTH-1:0] data_out,
  output logic             tc
`ifdef MOD_COUNTER_WRAP_CNT_EN
  ,
  output logic [WRAP_W-1:0] wrap_cnt
`endif
);

  if (MODULUS < 2) begin : g_bad_modulus_low
    $error("mod_n_counter: MODULUS must be at least 2");
  end
  if (64'(MODULUS) > (64'(1) << WIDTH)) begin : g_bad_modulus_high
    $error("mod_n_counter: MODULUS must not exceed 2**WIDTH");
  end
  if (WRAP_W < 1) begin : g_bad_wrap_w
    $error("mod_n_counter: WRAP_W must be at least 1");
  end

  logic [WIDTH-1:0] count_reg, count_next;
  logic             tc_reg, tc_next;
  logic [WIDTH-1:0] inc_value;
  logic [WIDTH-1:0] load_value;
  logic             wrap;

  mod_next_value #(
    .WIDTH  (WIDTH),
    .MODULUS(MODULUS)
  ) u_next (
    .count     (count_reg),
    .mode      (to_mode(mode)),
    .data_in   (data_in),
    .count_next(inc_value),
    .load_value(load_value),
    .wrap      (wrap)
  );

  // Load outranks counting, so a load on a would-be wrap edge is never a wrap.
  always_comb begin
    count_next = count_reg;
    tc_next    = 1'b0;
    if (load) begin
      count_next = load_value;
    end else if (en) begin
      count_next = inc_value;
      tc_next    = wrap;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_reg <= '0;
      tc_reg    <= 1'b0;
    end else begin
      count_reg <= count_next;
      tc_reg    <= tc_next;
    end
  end

  assign data_out = count_reg;
  assign tc       = tc_reg;

`ifdef MOD_COUNTER_WRAP_CNT_EN
  logic [WRAP_W-1:0] wrap_cnt_reg, wrap_cnt_next;

  always_comb begin
    wrap_cnt_next = wrap_cnt_reg;
    if (!load && en && wrap) begin
      wrap_cnt_next = wrap_cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wrap_cnt_reg <= '0;
    end else begin
      wrap_cnt_reg <= wrap_cnt_next;
    end
  end

  assign wrap_cnt = wrap_cnt_reg;
`endif

endmodule

// File: tb/tb_mod_n_counter.sv
// Bench for mod_n_counter: three configurations driven in lockstep and checked
// against an arithmetic model, with directed steps followed by random traffic.
module tb_mod_n_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, en, load, mode;
  logic [3:0] data_in;

  logic [3:0] q0, q1, q2;
  logic       tc0, tc1, tc2;
`ifdef MOD_COUNTER_WRAP_CNT_EN
  logic [7:0] w0, w1;
  logic [1:0] w2;
`endif

  mod_n_counter #(.WIDTH(4), .MODULUS(12), .WRAP_W(8)) dut0 (
    .clk(clk), .reset(reset), .en(en), .load(load), .data_in(data_in),
    .mode(mode), .data_out(q0), .tc(tc0)
`ifdef MOD_COUNTER_WRAP_CNT_EN
    , .wrap_cnt(w0)
`endif
  );

  mod_n_counter #(.WIDTH(4), .MODULUS(16), .WRAP_W(8)) dut1 (
    .clk(clk), .reset(reset), .en(en), .load(load), .data_in(data_in),
    .mode(mode), .data_out(q1), .tc(tc1)
`ifdef MOD_COUNTER_WRAP_CNT_EN
    , .wrap_cnt(w1)
`endif
  );

  mod_n_counter #(.WIDTH(4), .MODULUS(2), .WRAP_W(2)) dut2 (
    .clk(clk), .reset(reset), .en(en), .load(load), .data_in(data_in),
    .mode(mode), .data_out(q2), .tc(tc2)
`ifdef MOD_COUNTER_WRAP_CNT_EN
    , .wrap_cnt(w2)
`endif
  );

  int modv[3] = '{12, 16, 2};
  int wwv[3]  = '{8, 8, 2};
  int m_cnt[3];
  int m_tc[3];
  int m_wr[3];

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference behaviour written directly from the counting rules.
  function automatic void model_step();
    for (int i = 0; i < 3; i++) begin
      int m;
      bit w;
      m = modv[i];
      w = 1'b0;
      if (!reset) begin
        m_cnt[i] = 0;
        m_tc[i]  = 0;
        m_wr[i]  = 0;
      end else if (load) begin
        m_cnt[i] = (int'(data_in) < m) ? int'(data_in) : m - 1;
        m_tc[i]  = 0;
      end else if (en) begin
        if (mode) begin
          w        = (m_cnt[i] == m - 1);
          m_cnt[i] = (m_cnt[i] + 1) % m;
        end else begin
          w        = (m_cnt[i] == 0);
          m_cnt[i] = (m_cnt[i] + m - 1) % m;
        end
        m_tc[i] = w ? 1 : 0;
        if (w) m_wr[i] = (m_wr[i] + 1) % (1 << wwv[i]);
      end else begin
        m_tc[i] = 0;
      end
    end
  endfunction

  task automatic step(input logic r, input logic l, input logic e,
                      input logic md, input logic [3:0] d);
    reset   = r;
    load    = l;
    en      = e;
    mode    = md;
    data_in = d;
    @(posedge clk);
    model_step();
    #1;
    chk("d0 data_out", 32'(q0), 32'(m_cnt[0]));
    chk("d0 tc", 32'(tc0), 32'(m_tc[0]));
    chk("d1 data_out", 32'(q1), 32'(m_cnt[1]));
    chk("d1 tc", 32'(tc1), 32'(m_tc[1]));
    chk("d2 data_out", 32'(q2), 32'(m_cnt[2]));
    chk("d2 tc", 32'(tc2), 32'(m_tc[2]));
`ifdef MOD_COUNTER_WRAP_CNT_EN
    chk("d0 wrap_cnt", 32'(w0), 32'(m_wr[0]));
    chk("d1 wrap_cnt", 32'(w1), 32'(m_wr[1]));
    chk("d2 wrap_cnt", 32'(w2), 32'(m_wr[2]));
`endif
  endtask

  int exp_q[3]  = '{11, 0, 1};
  int exp_t[3]  = '{0, 1, 0};
  int exp_w2[9] = '{0, 1, 1, 2, 2, 3, 3, 0, 0};

  initial begin
    for (int i = 0; i < 3; i++) begin
      m_cnt[i] = 0;
      m_tc[i]  = 0;
      m_wr[i]  = 0;
    end
    @(negedge clk);

    // Reset wins over a simultaneous load.
    step(1'b0, 1'b1, 1'b1, 1'b1, 4'd5);
    chk("reset data_out", 32'(q0), 32'd0);
    chk("reset tc", 32'(tc0), 32'd0);

    // Load 10, count up through the wrap.
    step(1'b1, 1'b1, 1'b0, 1'b1, 4'd10);
    chk("load 10", 32'(q0), 32'd10);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b0, 1'b1, 1'b1, 4'd0);
      chk("up seq data_out", 32'(q0), 32'(exp_q[k]));
      chk("up seq tc", 32'(tc0), 32'(exp_t[k]));
    end
`ifdef MOD_COUNTER_WRAP_CNT_EN
    chk("up seq wrap_cnt", 32'(w0), 32'd1);
`endif

    // Load 1, count down through the wrap.
    step(1'b1, 1'b1, 1'b1, 1'b0, 4'd1);
    step(1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
    chk("down 0", 32'(q0), 32'd0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
    chk("down wrap value", 32'(q0), 32'd11);
    chk("down wrap tc", 32'(tc0), 32'd1);

    // Clamp, and a full-range modulus wrap.
    step(1'b1, 1'b1, 1'b0, 1'b1, 4'd14);
    chk("clamp 14", 32'(q0), 32'd11);
    step(1'b1, 1'b1, 1'b0, 1'b1, 4'd15);
    chk("m16 load 15", 32'(q1), 32'd15);
    step(1'b1, 1'b0, 1'b1, 1'b1, 4'd0);
    chk("m16 wrap value", 32'(q1), 32'd0);
    chk("m16 wrap tc", 32'(tc1), 32'd1);

    // Load beats a would-be wrap; then hold with en low.
    step(1'b1, 1'b1, 1'b0, 1'b1, 4'd11);
    step(1'b1, 1'b1, 1'b1, 1'b1, 4'd3);
    chk("load beats wrap value", 32'(q0), 32'd3);
    chk("load beats wrap tc", 32'(tc0), 32'd0);
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 4'(k));
      chk("hold", 32'(q0), 32'd3);
    end

    // Mid-count reset, then the MODULUS=2 wrap-counter rollover run.
    step(1'b1, 1'b0, 1'b1, 1'b1, 4'd0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 4'd7);
    chk("mid reset", 32'(q0), 32'd0);
    for (int k = 0; k < 9; k++) begin
      step(1'b1, 1'b0, 1'b1, 1'b1, 4'd0);
      chk("m2 tc", 32'(tc2), 32'(k % 2));
`ifdef MOD_COUNTER_WRAP_CNT_EN
      chk("m2 wrap_cnt", 32'(w2), 32'(exp_w2[k]));
`else
      chk("m2 data_out", 32'(q2), 32'((k + 1) % 2));
`endif
    end

    for (int k = 0; k < 400; k++) begin
      step(logic'($urandom_range(0, 40) != 0),
           logic'($urandom_range(0, 7) == 0),
           logic'($urandom_range(0, 3) != 0),
           logic'($urandom_range(0, 1)),
           4'($urandom_range(0, 15)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
